// File: rtl/cart_window_mapper.sv
// Cartridge bus decoder: programmable windows steer each CPU access to ROM (through a
// one-word fetch buffer), BSRAM, a coprocessor chip select, or open bus.
module cart_win_match (
  input  logic [31:0] cfg,
  input  logic [7:0]  bank,
  input  logic [3:0]  page,
  input  logic        romsel_n,
  output logic        hit,
  output logic [1:0]  tgt,
  output logic [1:0]  chip,
  output logic [1:0]  a0_src
);
  assign hit    = cfg[28]
                & (((bank ^ cfg[7:0])   & cfg[15:8])  == 8'h00)
                & (((page ^ cfg[19:16]) & cfg[23:20]) == 4'h0)
                & (~cfg[31] | ~romsel_n);
  assign tgt    = cfg[25:24];
  assign chip   = cfg[27:26];
  assign a0_src = cfg[30:29];
endmodule

module cart_window_mapper #(
  parameter int NWIN  = 4,
  parameter int NCHIP = 4,
  parameter int IW    = $clog2(NWIN)
) (
  input  logic               MCLK,
  input  logic               RST_N,
  input  logic [23:0]        CA,
  input  logic [7:0]         DI,
  output logic [7:0]         DO,
  input  logic               CPURD_N,
  input  logic               CPUWR_N,
  input  logic               ROMSEL_N,
  input  logic               SYSCLKF_CE,
  input  logic               SYSCLKR_CE,
  input  logic               MAP_MODE,
  input  logic [23:0]        ROM_MASK,
  input  logic [19:0]        BSRAM_MASK,
  input  logic               CFG_WE,
  input  logic [IW-1:0]      CFG_IDX,
  input  logic [31:0]        CFG_DATA,
  output logic               ROM_REQ,
  output logic [23:0]        ROM_ADDR,
  input  logic               ROM_ACK,
  input  logic [15:0]        ROM_Q,
  output logic               ROM_PEND,
  output logic [19:0]        BSRAM_ADDR,
  output logic [7:0]         BSRAM_D,
  input  logic [7:0]         BSRAM_Q,
  output logic               BSRAM_CE_N,
  output logic               BSRAM_OE_N,
  output logic               BSRAM_WE_N,
  output logic [NCHIP-1:0]   CHIP_CS,
  output logic               CHIP_A0,
  input  logic [8*NCHIP-1:0] CHIP_DO,
  output logic               MAP_ACTIVE
);
  localparam logic [1:0] T_ROM = 2'd0, T_BSRAM = 2'd1, T_CHIP = 2'd2, T_NONE = 2'd3;
  localparam logic [0:0] S_IDLE = 1'b0, S_FETCH = 1'b1;

  logic [NWIN-1:0][31:0] win_q;
  logic [NWIN-1:0]       win_hit;
  logic [NWIN-1:0][1:0]  win_tgt, win_chip, win_a0;

  genvar w;
  generate
    for (w = 0; w < NWIN; w++) begin : g_win
      always_ff @(posedge MCLK) begin
        if (!RST_N)                               win_q[w] <= '0;
        else if (CFG_WE && CFG_IDX == IW'(w))     win_q[w] <= CFG_DATA;
      end
      cart_win_match u_match (
        .cfg(win_q[w]), .bank(CA[23:16]), .page(CA[15:12]), .romsel_n(ROMSEL_N),
        .hit(win_hit[w]), .tgt(win_tgt[w]), .chip(win_chip[w]), .a0_src(win_a0[w])
      );
    end
  endgenerate

  // Walk from the top so the lowest-index hitting window is the last writer.
  logic [1:0] tgt, chip_id, a0_src;
  always_comb begin
    tgt     = ROMSEL_N ? T_NONE : T_ROM;
    chip_id = '0;
    a0_src  = '0;
    for (int i = NWIN-1; i >= 0; i--) begin
      if (win_hit[i]) begin
        tgt     = win_tgt[i];
        chip_id = win_chip[i];
        a0_src  = win_a0[i];
      end
    end
  end

  always_comb begin
    MAP_ACTIVE = 1'b0;
    for (int i = 0; i < NWIN; i++) MAP_ACTIVE = MAP_ACTIVE | win_q[i][28];
  end

  logic [23:0] xlat, rom_a;
  assign xlat  = MAP_MODE ? {2'b00, CA[21:0]} : {1'b0, CA[23:16], CA[14:0]};
  assign rom_a = xlat & ROM_MASK;

  logic [0:0]  state;
  logic        rom_req, buf_vld;
  logic [23:0] rom_addr;
  logic [22:0] buf_tag;
  logic [15:0] buf_dat;
  logic [7:0]  openbus;
  logic        rom_rd, buf_hit;

  assign buf_hit = buf_vld && (buf_tag == rom_a[23:1]);
  assign rom_rd  = SYSCLKF_CE && (tgt == T_ROM) && !CPURD_N;

  // The tag is taken at request time and valid is cleared until the word lands,
  // so an aborted or in-flight fetch can never look like a hit.
  always_ff @(posedge MCLK) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      rom_req  <= 1'b0;
      rom_addr <= '0;
      buf_vld  <= 1'b0;
      buf_tag  <= '0;
      buf_dat  <= '0;
      openbus  <= 8'hFF;
    end else begin
      if (SYSCLKR_CE) openbus <= DI;
      case (state)
        S_IDLE: if (rom_rd && !buf_hit) begin
          state    <= S_FETCH;
          rom_req  <= 1'b1;
          rom_addr <= {rom_a[23:1], 1'b0};
          buf_tag  <= rom_a[23:1];
          buf_vld  <= 1'b0;
        end
        default: if (ROM_ACK) begin
          state   <= S_IDLE;
          rom_req <= 1'b0;
          buf_dat <= ROM_Q;
          buf_vld <= 1'b1;
        end
      endcase
      if (CFG_WE) buf_vld <= 1'b0;
    end
  end

  assign ROM_REQ  = rom_req;
  assign ROM_ADDR = rom_addr;
  assign ROM_PEND = (state == S_FETCH);

  logic is_bs;
  assign is_bs      = (tgt == T_BSRAM);
  assign BSRAM_ADDR = xlat[19:0] & BSRAM_MASK;
  assign BSRAM_D    = DI;
  assign BSRAM_CE_N = ~is_bs;
  assign BSRAM_OE_N = is_bs ? CPURD_N : 1'b1;
  assign BSRAM_WE_N = is_bs ? CPUWR_N : 1'b1;

  // Chip ids beyond NCHIP select nothing and read back as open bus.
  logic [7:0] chip_q;
  logic       a0_raw;
  always_comb begin
    CHIP_CS = '0;
    chip_q  = openbus;
    for (int c = 0; c < NCHIP; c++) begin
      if (tgt == T_CHIP && chip_id == 2'(c)) begin
        CHIP_CS[c] = 1'b1;
        chip_q     = CHIP_DO[c*8 +: 8];
      end
    end
    case (a0_src)
      2'd0:    a0_raw = CA[0];
      2'd1:    a0_raw = CA[12];
      2'd2:    a0_raw = CA[14];
      default: a0_raw = 1'b1;
    endcase
  end
  assign CHIP_A0 = (tgt == T_CHIP) & a0_raw;

  always_comb begin
    case (tgt)
      T_ROM:   DO = ROM_PEND ? openbus : (rom_a[0] ? buf_dat[15:8] : buf_dat[7:0]);
      T_CHIP:  DO = chip_q;
      T_BSRAM: DO = BSRAM_Q;
      default: DO = openbus;
    endcase
  end
endmodule

// File: tb/tb_cart_window_mapper.sv
// Bench for cart_window_mapper: directed ROM-fetch sequences, a decode vector table,
// and randomized decode against a behavioural window model.
module tb_cart_window_mapper;
  localparam int NWIN = 4, NCHIP = 4, IW = 2;

  logic MCLK = 1'b0;
  logic RST_N;
  logic [23:0] CA;
  logic [7:0]  DI, DO;
  logic CPURD_N, CPUWR_N, ROMSEL_N, SYSCLKF_CE, SYSCLKR_CE, MAP_MODE;
  logic [23:0] ROM_MASK;
  logic [19:0] BSRAM_MASK;
  logic CFG_WE;
  logic [IW-1:0] CFG_IDX;
  logic [31:0] CFG_DATA;
  logic ROM_REQ, ROM_ACK, ROM_PEND;
  logic [23:0] ROM_ADDR;
  logic [15:0] ROM_Q;
  logic [19:0] BSRAM_ADDR;
  logic [7:0]  BSRAM_D, BSRAM_Q;
  logic BSRAM_CE_N, BSRAM_OE_N, BSRAM_WE_N;
  logic [NCHIP-1:0] CHIP_CS;
  logic CHIP_A0;
  logic [8*NCHIP-1:0] CHIP_DO;
  logic MAP_ACTIVE;

  cart_window_mapper #(.NWIN(NWIN), .NCHIP(NCHIP), .IW(IW)) dut (
    .MCLK(MCLK), .RST_N(RST_N), .CA(CA), .DI(DI), .DO(DO),
    .CPURD_N(CPURD_N), .CPUWR_N(CPUWR_N), .ROMSEL_N(ROMSEL_N),
    .SYSCLKF_CE(SYSCLKF_CE), .SYSCLKR_CE(SYSCLKR_CE), .MAP_MODE(MAP_MODE),
    .ROM_MASK(ROM_MASK), .BSRAM_MASK(BSRAM_MASK),
    .CFG_WE(CFG_WE), .CFG_IDX(CFG_IDX), .CFG_DATA(CFG_DATA),
    .ROM_REQ(ROM_REQ), .ROM_ADDR(ROM_ADDR), .ROM_ACK(ROM_ACK), .ROM_Q(ROM_Q), .ROM_PEND(ROM_PEND),
    .BSRAM_ADDR(BSRAM_ADDR), .BSRAM_D(BSRAM_D), .BSRAM_Q(BSRAM_Q),
    .BSRAM_CE_N(BSRAM_CE_N), .BSRAM_OE_N(BSRAM_OE_N), .BSRAM_WE_N(BSRAM_WE_N),
    .CHIP_CS(CHIP_CS), .CHIP_A0(CHIP_A0), .CHIP_DO(CHIP_DO), .MAP_ACTIVE(MAP_ACTIVE)
  );

  always #5 MCLK = ~MCLK;

  int tests = 0, fails = 0;
  logic [31:0] mdl_win [NWIN];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge MCLK); #1;
  endtask

  task automatic cfg_wr(input int idx, input logic [31:0] d);
    CFG_IDX = IW'(idx); CFG_DATA = d; CFG_WE = 1'b1;
    cyc();
    CFG_WE = 1'b0;
    mdl_win[idx] = d;
  endtask

  task automatic pulse_f();
    SYSCLKF_CE = 1'b1; cyc(); SYSCLKF_CE = 1'b0; #2;
  endtask

  task automatic latch_ob(input logic [7:0] v);
    DI = v; SYSCLKR_CE = 1'b1; cyc(); SYSCLKR_CE = 1'b0;
  endtask

  // Reference decode: masked compare of bank/page fields, first enabled hit wins.
  function automatic void mdl_dec(input logic [23:0] ca, input logic rs_n,
                                  output logic [1:0] tgt, output logic [1:0] chip, output logic [1:0] a0s);
    logic [31:0] c;
    tgt = rs_n ? 2'd3 : 2'd0; chip = 2'd0; a0s = 2'd0;
    for (int w = 0; w < NWIN; w++) begin
      c = mdl_win[w];
      if (c[28] && ((ca[23:16] & c[15:8]) == (c[7:0] & c[15:8]))
          && ((ca[15:12] & c[23:20]) == (c[19:16] & c[23:20])) && (!c[31] || !rs_n)) begin
        tgt = c[25:24]; chip = c[27:26]; a0s = c[30:29];
        break;
      end
    end
  endfunction

  typedef struct {
    logic [23:0] ca;
    logic rd_n, wr_n, rs_n;
    logic [3:0] cs;
    logic a0, ce_n, we_n;
    logic [7:0] dout;
    logic chk_do;
  } vec_t;
  vec_t tbl [9];

  initial begin
    logic [1:0] et, ec, ea;
    logic [23:0] ex;
    logic [31:0] d;
    logic ea0;

    for (int i = 0; i < NWIN; i++) mdl_win[i] = '0;
    tbl[0] = '{24'h700123, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 8'h99, 1'b1};
    tbl[1] = '{24'h714000, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 8'h99, 1'b1};
    tbl[2] = '{24'h700005, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 8'h99, 1'b1};
    tbl[3] = '{24'h30C000, 1'b0, 1'b1, 1'b1, 4'h4, 1'b1, 1'b1, 1'b1, 8'h33, 1'b1};
    tbl[4] = '{24'h3F8001, 1'b0, 1'b1, 1'b1, 4'h4, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1};
    tbl[5] = '{24'h304000, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1};
    tbl[6] = '{24'hC51234, 1'b0, 1'b1, 1'b0, 4'h2, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1};
    tbl[7] = '{24'hC51234, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1};
    tbl[8] = '{24'h008000, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0};

    RST_N = 1'b0; CA = 24'h808000; DI = 8'h00; CPURD_N = 1'b1; CPUWR_N = 1'b1; ROMSEL_N = 1'b1;
    SYSCLKF_CE = 1'b0; SYSCLKR_CE = 1'b0; MAP_MODE = 1'b0;
    ROM_MASK = 24'h3FFFFF; BSRAM_MASK = 20'h07FFF;
    CFG_WE = 1'b1; CFG_IDX = '0; CFG_DATA = 32'hFFFF_FFFF;
    ROM_ACK = 1'b0; ROM_Q = 16'h0000; BSRAM_Q = 8'h99; CHIP_DO = 32'h4433_2211;
    repeat (3) cyc();
    CFG_WE = 1'b0;
    #2;
    chk("rst_req",    32'(ROM_REQ), 0);
    chk("rst_addr",   32'(ROM_ADDR), 0);
    chk("rst_pend",   32'(ROM_PEND), 0);
    chk("rst_active", 32'(MAP_ACTIVE), 0);
    chk("rst_cs",     32'(CHIP_CS), 0);
    chk("rst_ce_n",   32'(BSRAM_CE_N), 1);
    chk("rst_do",     32'(DO), 'hFF);

    // ROM miss, held request, ignored SYSCLKF while pending, then ACK.
    RST_N = 1'b1; cyc();
    ROMSEL_N = 1'b0; CPURD_N = 1'b0;
    pulse_f();
    chk("miss_req",  32'(ROM_REQ), 1);
    chk("miss_addr", 32'(ROM_ADDR), 0);
    chk("miss_pend", 32'(ROM_PEND), 1);
    chk("pend_do",   32'(DO), 'hFF);
    repeat (2) cyc();
    chk("req_held",  32'(ROM_REQ), 1);
    CA = 24'h808010; pulse_f();
    chk("no_rereq_addr", 32'(ROM_ADDR), 0);
    CA = 24'h808000;
    ROM_ACK = 1'b1; ROM_Q = 16'hBEEF; cyc(); ROM_ACK = 1'b0; #2;
    chk("ack_req",  32'(ROM_REQ), 0);
    chk("ack_pend", 32'(ROM_PEND), 0);
    chk("ack_do_lo", 32'(DO), 'hEF);
    CA = 24'h808001; pulse_f();
    chk("hit_noreq", 32'(ROM_REQ), 0);
    chk("hit_do_hi", 32'(DO), 'hBE);
    ROM_ACK = 1'b1; ROM_Q = 16'hFFFF; cyc(); ROM_ACK = 1'b0; #2;
    chk("idle_ack_ign", 32'(DO), 'hBE);
    cfg_wr(3, 32'h0000_0000);
    pulse_f();
    chk("inval_req",  32'(ROM_REQ), 1);
    chk("inval_addr", 32'(ROM_ADDR), 0);
    ROM_ACK = 1'b1; ROM_Q = 16'h1234; cyc(); ROM_ACK = 1'b0; #2;
    chk("refetch_do", 32'(DO), 'h12);

    // BSRAM window write.
    cfg_wr(0, 32'h1100_FE70);
    CA = 24'h700123; DI = 8'h5A; CPUWR_N = 1'b0; CPURD_N = 1'b1; ROMSEL_N = 1'b1; #2;
    chk("bs_we_n",  32'(BSRAM_WE_N), 0);
    chk("bs_ce_n",  32'(BSRAM_CE_N), 0);
    chk("bs_oe_n",  32'(BSRAM_OE_N), 1);
    chk("bs_addr",  32'(BSRAM_ADDR), 'h00123);
    chk("bs_d",     32'(BSRAM_D), 'h5A);
    chk("active",   32'(MAP_ACTIVE), 1);
    CPUWR_N = 1'b1;

    // Chip windows, then the decode table.
    cfg_wr(1, 32'h5A88_E020);
    cfg_wr(2, 32'hF600_C0C0);
    latch_ob(8'hA5);
    for (int i = 0; i < 9; i++) begin
      CA = tbl[i].ca; CPURD_N = tbl[i].rd_n; CPUWR_N = tbl[i].wr_n; ROMSEL_N = tbl[i].rs_n; #2;
      chk($sformatf("tbl%0d_cs", i),   32'(CHIP_CS),    32'(tbl[i].cs));
      chk($sformatf("tbl%0d_a0", i),   32'(CHIP_A0),    32'(tbl[i].a0));
      chk($sformatf("tbl%0d_ce", i),   32'(BSRAM_CE_N), 32'(tbl[i].ce_n));
      chk($sformatf("tbl%0d_we", i),   32'(BSRAM_WE_N), 32'(tbl[i].we_n));
      if (tbl[i].chk_do) chk($sformatf("tbl%0d_do", i), 32'(DO), 32'(tbl[i].dout));
    end

    // Randomized decode against the model; SYSCLK enables stay low so no fetches start.
    for (int i = 0; i < 150; i++) begin
      for (int w = 0; w < NWIN; w++) begin
        d = $urandom;
        if ($urandom_range(0, 1) == 1) d[15:8] = 8'h00;
        if ($urandom_range(0, 1) == 1) d[23:20] = 4'h0;
        d[28] = ($urandom_range(0, 3) != 0);
        cfg_wr(w, d);
      end
      CA = 24'($urandom); ROMSEL_N = 1'($urandom_range(0, 1));
      CPURD_N = 1'($urandom_range(0, 1)); CPUWR_N = 1'($urandom_range(0, 1));
      MAP_MODE = 1'($urandom_range(0, 1)); BSRAM_MASK = 20'($urandom);
      #2;
      mdl_dec(CA, ROMSEL_N, et, ec, ea);
      ex = MAP_MODE ? (CA & 24'h3FFFFF) : ((24'(CA[23:16]) << 15) | (CA & 24'h007FFF));
      case (ea)
        2'd0: ea0 = CA[0];
        2'd1: ea0 = CA[12];
        2'd2: ea0 = CA[14];
        default: ea0 = 1'b1;
      endcase
      chk("rnd_cs",   32'(CHIP_CS),    (et == 2'd2) ? (32'd1 << ec) : 32'd0);
      chk("rnd_a0",   32'(CHIP_A0),    (et == 2'd2) ? 32'(ea0) : 32'd0);
      chk("rnd_ce",   32'(BSRAM_CE_N), (et == 2'd1) ? 32'd0 : 32'd1);
      chk("rnd_oe",   32'(BSRAM_OE_N), (et == 2'd1) ? 32'(CPURD_N) : 32'd1);
      chk("rnd_we",   32'(BSRAM_WE_N), (et == 2'd1) ? 32'(CPUWR_N) : 32'd1);
      chk("rnd_addr", 32'(BSRAM_ADDR), 32'(ex[19:0] & BSRAM_MASK));
      if (et != 2'd0)
        chk("rnd_do", 32'(DO), (et == 2'd2) ? 32'((CHIP_DO >> (8 * ec)) & 32'hFF) :
                               (et == 2'd1) ? 32'h99 : 32'hA5);
    end

    // Window 0 overlaps window 1 and wins with target NONE.
    MAP_MODE = 1'b0; BSRAM_MASK = 20'h07FFF;
    cfg_wr(0, 32'h1300_FF30); cfg_wr(1, 32'h5A88_E020); cfg_wr(2, 32'h0); cfg_wr(3, 32'h0);
    latch_ob(8'h30);
    DI = 8'h00; CA = 24'h30C000; ROMSEL_N = 1'b1; CPURD_N = 1'b0; CPUWR_N = 1'b1; #2;
    chk("prio_do", 32'(DO), 'h30);
    chk("prio_cs", 32'(CHIP_CS), 0);

    // Reset in the middle of a fetch, then a late ACK.
    cfg_wr(0, 32'h0); cfg_wr(1, 32'h0);
    CA = 24'h808000; ROMSEL_N = 1'b0;
    pulse_f();
    chk("abort_req0", 32'(ROM_REQ), 1);
    RST_N = 1'b0; cyc(); #2;
    chk("abort_req",  32'(ROM_REQ), 0);
    chk("abort_pend", 32'(ROM_PEND), 0);
    RST_N = 1'b1;
    ROM_ACK = 1'b1; ROM_Q = 16'hDEAD; cyc(); ROM_ACK = 1'b0; #2;
    chk("late_ack_req", 32'(ROM_REQ), 0);
    pulse_f();
    chk("abort_inval", 32'(ROM_REQ), 1);
    ROM_ACK = 1'b1; ROM_Q = 16'h00C3; cyc(); ROM_ACK = 1'b0; #2;
    chk("final_do", 32'(DO), 'hC3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
